// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// load/store size encodings, controller state enum, default bus timeout
// and the store-data lane replication helper.
package mem_access_ctrl_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WORD = 2'b01;
  localparam logic [1:0] OP_HALF = 2'b10;
  localparam logic [1:0] OP_BYTE = 2'b11;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Copy right-aligned store data into every lane it may be written from,
  // so the byte enables alone select the destination bytes on the bus.
  function automatic logic [31:0] replicate_store(input logic [1:0] op,
                                                  input logic [31:0] d);
    case (op)
      OP_BYTE: return {4{d[7:0]}};
      OP_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational load-data lane select and sign/zero extension.
// Byte lane comes from addr[1:0], half lane from addr[1]; words pass through.
module mem_access_ctrl_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_sign,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it to 32 bits.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_word;
    case (i_op)
      OP_BYTE: begin
        case (i_addr_lo)
          2'd0:    w_byte = i_word[7:0];
          2'd1:    w_byte = i_word[15:8];
          2'd2:    w_byte = i_word[23:16];
          default: w_byte = i_word[31:24];
        endcase
        o_data = i_sign ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      end
      OP_HALF: begin
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_sign ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      end
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Accepts a load/store request,
// holds it on a req/ack bus while stalling the pipeline, returns extended
// load data in the DONE cycle and aborts with bus_err after TIMEOUT cycles
// without an acknowledge.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects misaligned word/half
// accesses with a misalign pulse instead of issuing them.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  s_l_op,
  input  logic        ld_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  BE,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic        r_we;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [CW-1:0] r_cnt;

  logic        w_op_valid;
  logic        w_unaligned;
  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_ext;

  assign w_op_valid = req_valid && (s_l_op != OP_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_unaligned = ((s_l_op == OP_WORD) && (addr[1:0] != 2'b00)) ||
                       ((s_l_op == OP_HALF) && addr[0]);
`else
  assign w_unaligned = 1'b0;
`endif

  assign w_accept  = w_op_valid && !w_unaligned;
  assign w_timeout = (r_state == ST_REQ) && !bus_ack &&
                     (r_cnt == CW'(TIMEOUT - 1));

  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  assign rdata     = r_rdata;

  mem_access_ctrl_load_extend u_load_extend (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_sign    (r_sign),
    .i_word    (bus_rdata),
    .o_data    (w_ext)
  );

  // State register; reset drops the bus request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and control outputs.
  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    misalign    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        misalign = w_op_valid && w_unaligned;
        if (w_accept) begin
          stall  = 1'b1;
          w_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        bus_we  = r_we;
        if (bus_ack || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: begin
        // The finished instruction is still in MEM here; req_valid is ignored.
        rdata_valid = !r_we && !r_err;
        bus_err     = r_err;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and load-result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= OP_NONE;
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_addr  <= 32'h0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= s_l_op;
            r_we    <= req_we;
            r_sign  <= ld_sign;
            r_addr  <= addr;
            r_be    <= BE;
            r_wdata <= replicate_store(s_l_op, wdata);
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            if (!r_we) r_rdata <= w_ext;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT = 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  s_l_op;
  logic        ld_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  BE;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_err;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .s_l_op(s_l_op), .ld_sign(ld_sign), .addr(addr), .wdata(wdata), .BE(BE),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
    .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] op, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    s_l_op    = op;
    ld_sign   = sgn;
    addr      = a;
    wdata     = wd;
    BE        = be;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; s_l_op = OP_NONE;
    ld_sign = 1'b0; addr = 32'h0; wdata = 32'h0; BE = 4'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++; if ({rdata_valid, bus_err, misalign, bus_we} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b want 0000", {rdata_valid, bus_err, misalign, bus_we}); end
    checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin errors++; $display("FAIL rst_bus_regs: got %h/%h/%h want 0", bus_addr, bus_be, bus_wdata); end
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_store_byte();
    int sc = 0;
    cyc();
    issue(1'b1, OP_BYTE, 1'b0, 32'h0000_1003, 32'h0000_00AB, 4'b1000);
    smp(); if (stall === 1'b1) sc++;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sb_idle_req: got %b want 0", bus_req); end
    cyc();
    bus_ack = 1'b1;
    smp(); if (stall === 1'b1) sc++;
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL sb_req_we: got %b%b want 11", bus_req, bus_we); end
    checks++; if (bus_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h want 00001000", bus_addr); end
    checks++; if (bus_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", bus_wdata); end
    checks++; if (bus_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b want 1000", bus_be); end
    cyc();
    bus_ack = 1'b0;   // req_valid stays high: DONE must ignore it
    smp(); if (stall === 1'b1) sc++;
    checks++; if (rdata_valid !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL sb_done: rv=%b req=%b want 0 0", rdata_valid, bus_req); end
    cyc();
    req_valid = 1'b0;
    smp(); if (stall === 1'b1) sc++;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sb_back_idle: req=%b want 0", bus_req); end
    checks++; if (sc != 2) begin errors++; $display("FAIL sb_stall_cycles: got %0d want 2", sc); end
  endtask

  task automatic test_stores();
    logic [1:0]  op [3] = '{OP_HALF, OP_WORD, OP_BYTE};
    logic [31:0] ad [3] = '{32'h0000_6002, 32'h0000_6004, 32'h0000_6001};
    logic [31:0] wd [3] = '{32'h1234_ABCD, 32'hDEAD_BEEF, 32'h0000_005A};
    logic [3:0]  be [3] = '{4'b1100, 4'b1111, 4'b0000};
    logic [31:0] ea [3] = '{32'h0000_6000, 32'h0000_6004, 32'h0000_6000};
    logic [31:0] ew [3] = '{32'hABCD_ABCD, 32'hDEAD_BEEF, 32'h5A5A_5A5A};
    for (int i = 0; i < 3; i++) begin
      cyc();
      issue(1'b1, op[i], 1'b0, ad[i], wd[i], be[i]);
      cyc();
      req_valid = 1'b0;
      bus_ack = 1'b1;
      smp();
      checks++; if (bus_req !== 1'b1 || bus_addr !== ea[i]) begin errors++; $display("FAIL st%0d_addr: req=%b got %h want %h", i, bus_req, bus_addr, ea[i]); end
      checks++; if (bus_wdata !== ew[i] || bus_be !== be[i]) begin errors++; $display("FAIL st%0d_data: got %h/%b want %h/%b", i, bus_wdata, bus_be, ew[i], be[i]); end
      cyc();
      bus_ack = 1'b0;
      smp();
      checks++; if (rdata_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL st%0d_done: rv=%b stall=%b want 0 0", i, rdata_valid, stall); end
    end
  endtask

  task automatic test_load_half_wait();
    int sc = 0;
    cyc();
    issue(1'b0, OP_HALF, 1'b1, 32'h0000_2002, 32'h0, 4'b1100);
    smp(); if (stall === 1'b1) sc++;
    cyc();
    req_valid = 1'b0;
    bus_rdata = 32'h8001_1234;
    for (int w = 0; w < 3; w++) begin
      smp(); if (stall === 1'b1) sc++;
      checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL lh_wait%0d: req=%b we=%b want 1 0", w, bus_req, bus_we); end
      cyc();
    end
    bus_ack = 1'b1;
    smp(); if (stall === 1'b1) sc++;
    cyc();
    bus_ack = 1'b0;
    smp(); if (stall === 1'b1) sc++;
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_result: rv=%b got %h want 1 ffff8001", rdata_valid, rdata); end
    checks++; if (sc != 5) begin errors++; $display("FAIL lh_stall_cycles: got %0d want 5", sc); end
    cyc();
    smp();
    checks++; if (rdata_valid !== 1'b0 || rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_hold: rv=%b got %h want 0 ffff8001", rdata_valid, rdata); end
  endtask

  task automatic test_loads();
    logic [1:0]  op [8] = '{OP_BYTE, OP_BYTE, OP_BYTE, OP_BYTE, OP_HALF, OP_HALF, OP_HALF, OP_WORD};
    logic        sg [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad [8] = '{32'h2001, 32'h2001, 32'h2003, 32'h2000, 32'h2000, 32'h2002, 32'h2000, 32'h2000};
    logic [31:0] rd [8] = '{32'h0000_F200, 32'h0000_F200, 32'h7F00_0000, 32'h1234_56AB,
                            32'h8001_1234, 32'h8001_1234, 32'h0000_F00F, 32'h8001_1234};
    logic [31:0] ex [8] = '{32'h0000_00F2, 32'hFFFF_FFF2, 32'h0000_007F, 32'h0000_00AB,
                            32'h0000_1234, 32'h0000_8001, 32'hFFFF_F00F, 32'h8001_1234};
    for (int i = 0; i < 8; i++) begin
      cyc();
      issue(1'b0, op[i], sg[i], ad[i], 32'h0, 4'b1111);
      cyc();
      req_valid = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = rd[i];
      cyc();
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
      smp();
      checks++; if (rdata_valid !== 1'b1 || rdata !== ex[i] || stall !== 1'b0) begin errors++; $display("FAIL ld%0d: rv=%b stall=%b got %h want 1 0 %h", i, rdata_valid, stall, rdata, ex[i]); end
    end
  endtask

  task automatic test_timeout();
    int rq = 0;
    int ec = 0;
    logic [31:0] err_rd = 32'hFFFF_FFFF;
    cyc();
    issue(1'b0, OP_WORD, 1'b0, 32'h0000_4000, 32'h0, 4'b1111);
    cyc();
    req_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      smp();
      if (bus_req === 1'b1) rq++;
      if (bus_err === 1'b1) begin ec++; err_rd = rdata; end
      cyc();
    end
    smp();
    checks++; if (rq != 16) begin errors++; $display("FAIL to_req_cycles: got %0d want 16", rq); end
    checks++; if (ec != 1) begin errors++; $display("FAIL to_err_pulses: got %0d want 1", ec); end
    checks++; if (err_rd !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", err_rd); end
    checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL to_idle: stall=%b req=%b want 0 0", stall, bus_req); end
  endtask

  task automatic test_ack_on_last();
    int rq = 0;
    cyc();
    issue(1'b0, OP_WORD, 1'b0, 32'h0000_4000, 32'h0, 4'b1111);
    cyc();
    req_valid = 1'b0;
    bus_rdata = 32'h1234_5678;
    for (int c = 1; c <= 16; c++) begin
      bus_ack = (c == 16);
      smp();
      if (bus_req === 1'b1) rq++;
      cyc();
    end
    bus_ack = 1'b0;
    smp();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL al_err: got %b want 0", bus_err); end
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h1234_5678) begin errors++; $display("FAIL al_result: rv=%b got %h want 1 12345678", rdata_valid, rdata); end
    checks++; if (rq != 16) begin errors++; $display("FAIL al_req_cycles: got %0d want 16", rq); end
  endtask

  task automatic test_ack_outside();
    cyc();
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    smp();
    checks++; if (rdata_valid !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL ao_idle: rv=%b stall=%b req=%b want 000", rdata_valid, stall, bus_req); end
    cyc();
    bus_ack = 1'b0;
    smp();
    checks++; if (rdata !== 32'h1234_5678 || rdata_valid !== 1'b0) begin errors++; $display("FAIL ao_hold: rv=%b got %h want 0 12345678", rdata_valid, rdata); end
  endtask

  task automatic test_reset_mid_req();
    cyc();
    issue(1'b0, OP_WORD, 1'b0, 32'h0000_5000, 32'h0, 4'b1111);
    cyc();
    req_valid = 1'b0;
    smp();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_pre_req: got %b want 1", bus_req); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rm_async: req=%b stall=%b want 0 0", bus_req, stall); end
    checks++; if (bus_addr !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL rm_regs: addr=%h rdata=%h want 0 0", bus_addr, rdata); end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    cyc();
    issue(1'b1, OP_WORD, 1'b0, 32'h0000_5004, 32'hDEAD_BEEF, 4'b1111);
    smp();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rm_accept: stall=%b want 1", stall); end
    cyc();
    req_valid = 1'b0;
    bus_ack = 1'b1;
    smp();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_5004 || bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rm_fresh: req=%b addr=%h wd=%h want 1 00005004 deadbeef", bus_req, bus_addr, bus_wdata); end
    cyc();
    bus_ack = 1'b0;
    smp();
    checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL rm_done: stall=%b req=%b want 0 0", stall, bus_req); end
  endtask

  task automatic test_align();
    cyc();
    issue(1'b0, OP_WORD, 1'b0, 32'h0000_3002, 32'h0, 4'b1111);
`ifdef MEM_ALIGN_CHECK_EN
    smp();
    checks++; if (misalign !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL al_word_rej: mis=%b stall=%b want 1 0", misalign, stall); end
    cyc();
    s_l_op = OP_HALF;
    addr = 32'h0000_3001;
    smp();
    checks++; if (misalign !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL al_half_rej: mis=%b req=%b want 1 0", misalign, bus_req); end
    cyc();
    req_valid = 1'b0;
    smp();
    checks++; if (misalign !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL al_idle: mis=%b req=%b stall=%b want 000", misalign, bus_req, stall); end
`else
    smp();
    checks++; if (misalign !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL al_nocheck: mis=%b stall=%b want 0 1", misalign, stall); end
    cyc();
    req_valid = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    smp();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0000_3000) begin errors++; $display("FAIL al_issue: req=%b addr=%h want 1 00003000", bus_req, bus_addr); end
    cyc();
    bus_ack = 1'b0;
    smp();
    checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL al_result: rv=%b got %h want 1 cafef00d", rdata_valid, rdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_stores();
    test_load_half_wait();
    test_loads();
    test_timeout();
    test_ack_on_last();
    test_ack_outside();
    test_reset_mid_req();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory access controller sitting directly downstream of the byte-enable generator in the MEM stage. It takes the MEM-stage load/store request (op, address, store data, byte enables), drives a req/ack data bus, stalls the pipeline until the bus completes, and returns lane-extracted, sign- or zero-extended load data. A bounded wait counter aborts hung transactions with an error pulse.

## Interface
- `TIMEOUT`, 16: max cycles `bus_req` is held without `bus_ack` before abort (≥2).
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage holds a memory instruction.
- `req_we`  in  1  1 = store, 0 = load.
- `s_l_op`  in  2  00 none, 01 word, 10 half, 11 byte.
- `ld_sign`  in  1  load is sign-extended (lb/lh); ignored for word/store.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned.
- `BE`  in  4  byte enables from the byte-enable generator.
- `stall`  out  1  freeze pipeline at and before MEM.
- `rdata`  out  32  extended load result.
- `rdata_valid`  out  1  one-cycle pulse, `rdata` valid.
- `bus_err`  out  1  one-cycle pulse, timeout abort.
- `misalign`  out  1  one-cycle pulse, misaligned access rejected (macro only).
- `bus_req`, `bus_we`  out  1  bus request / write.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`.
- `bus_be`  out  4  registered `BE`.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  bus completes this cycle.
- `bus_rdata`  in  32  read word, valid with `bus_ack`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: accept when `req_valid && s_l_op!=00` (and aligned under macro); register op, we, sign, addr, BE, replicated data; → REQ.
- Store data replication: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- REQ: `bus_req`=1, bus outputs from registers, stable until ack. On `bus_ack`: loads capture extracted word → DONE. Wait counter increments per cycle without ack; at count TIMEOUT-1 without ack → DONE with `bus_err`, `rdata`=0.
- Load extraction: byte lane `addr[1:0]`, half lane `addr[1]`; extend per `ld_sign`; word passed through.
- DONE: `rdata_valid`=1 for loads (0 for stores), `stall`=0; `req_valid` ignored (same instruction still present); → IDLE.
- `stall` = (IDLE && accept condition) || REQ.
- `BE`=0000 with nonzero op: issued as is; no special case.

## Timing
- Reset (async, immediate): state IDLE, counter 0, all outputs 0, `bus_req` drops same instant.
- Minimum access: accept cycle (stall), REQ with ack same cycle, DONE → 3 cycles, result in DONE.
- `bus_ack` on timeout cycle: ack wins, normal completion.
- `bus_ack` outside REQ ignored.
- `rdata` holds last value until next load completes or abort.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: word with `addr[1:0]!=0` or half with `addr[0]!=0` not accepted; `misalign` pulses in IDLE, `stall`=0, state stays IDLE, no bus activity.
- Undefined: no check; `misalign` tied 0; access issued with given `BE`.

## Structure
- Shared package: `s_l_op` encodings (OP_NONE/WORD/HALF/BYTE), state enum, default TIMEOUT.
- Sub-module `load_extend`: combinational lane select + sign/zero extension (op, addr[1:0], sign, word → 32-bit).

## Test plan
- Store byte, addr 0x1003, wdata 0xAB, BE 1000, ack in 1st REQ cycle -> `bus_addr` 0x1000, `bus_wdata` 0xABABABAB, `bus_be` 1000, stall 2 cycles, no `rdata_valid`.
- Load half signed, addr 0x2002, `bus_rdata` 0x8001_1234, ack after 3 wait cycles -> `rdata` 0xFFFF8001 pulsed in DONE, stall 5 cycles.
- Load byte unsigned, addr 0x2001, `bus_rdata` 0x0000_F200 -> `rdata` 0x000000F2.
- No ack, TIMEOUT=16 -> `bus_req` high 16 cycles, `bus_err` pulse, `rdata` 0, back to IDLE; ack on 16th cycle -> normal completion, no error.
- `reset_n` low mid-REQ -> `bus_req`, `stall` 0 immediately; after release IDLE, fresh request accepted.
- With `MEM_ALIGN_CHECK_EN`: load word addr 0x3002 -> `misalign` pulse, no `bus_req`, `stall` 0.
